// File: rtl/ov7670_frame_tx.sv
// OV7670-style sensor-side frame transmitter paced by the master's PCLK.
// Define OV7670_TEST_PATTERN_EN to replace the pixel stream with an h^l test pattern.
module ov7670_frame_tx #(
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned H_BLANK       = 144,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned VSYNC_LINES   = 3,
   parameter int unsigned V_BACK_LINES  = 17,
   parameter int unsigned V_FRONT_LINES = 10,
   parameter int unsigned DWIDTH        = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              PCLK,
   input  logic [DWIDTH-1:0] pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              VSYNC,
   output logic              HREF,
   output logic [DWIDTH-1:0] data,
   output logic              frame_start,
   output logic              frame_done,
   output logic              underflow
);

   localparam int unsigned LINE_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned HW         = (LINE_TOTAL > 1) ? $clog2(LINE_TOTAL) : 1;
   localparam int unsigned LMAX_A     = (VSYNC_LINES > V_BACK_LINES) ? VSYNC_LINES : V_BACK_LINES;
   localparam int unsigned LMAX_B     = (V_ACTIVE > V_FRONT_LINES) ? V_ACTIVE : V_FRONT_LINES;
   localparam int unsigned LMAX       = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
   localparam int unsigned LW         = (LMAX > 1) ? $clog2(LMAX) : 1;

   typedef enum logic [2:0] {IDLE, VSYNC_S, V_BACK, ACTIVE, V_FRONT} state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [LW-1:0]     l_cnt_q, l_cnt_d;
   logic              pclk_q;
   logic              vsync_q, vsync_d;
   logic              href_q, href_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              pix_ready_q, pix_ready_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_done_q, frame_done_d;
   logic              underflow_q, underflow_d;

   logic              tick;
   logic              h_wrap;
   logic [HW-1:0]     h_inc;
   logic [LW-1:0]     l_inc;

   assign tick   = PCLK & ~pclk_q;
   assign h_wrap = (h_cnt_q == HW'(LINE_TOTAL - 1));
   assign h_inc  = h_wrap ? '0 : h_cnt_q + HW'(1);
   assign l_inc  = l_cnt_q + LW'(1);

`ifdef OV7670_TEST_PATTERN_EN
   logic unused_stream;
   assign unused_stream = ^{pix_data, pix_valid};
`endif

   // Counters hold the position of the tick period being started; outputs follow the new position.
   always_comb begin
      state_d       = state_q;
      h_cnt_d       = h_cnt_q;
      l_cnt_d       = l_cnt_q;
      vsync_d       = vsync_q;
      href_d        = href_q;
      data_d        = data_q;
      pix_ready_d   = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      underflow_d   = underflow_q;

      if (tick) begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_d       = VSYNC_S;
                  h_cnt_d       = '0;
                  l_cnt_d       = '0;
                  frame_start_d = 1'b1;
               end
            end
            VSYNC_S: begin
               h_cnt_d = h_inc;
               if (h_wrap) begin
                  if (l_cnt_q == LW'(VSYNC_LINES - 1)) begin
                     l_cnt_d = '0;
                     state_d = V_BACK;
                  end else begin
                     l_cnt_d = l_inc;
                  end
               end
            end
            V_BACK: begin
               h_cnt_d = h_inc;
               if (h_wrap) begin
                  if (l_cnt_q == LW'(V_BACK_LINES - 1)) begin
                     l_cnt_d = '0;
                     state_d = ACTIVE;
                  end else begin
                     l_cnt_d = l_inc;
                  end
               end
            end
            ACTIVE: begin
               h_cnt_d = h_inc;
               if (h_wrap) begin
                  if (l_cnt_q == LW'(V_ACTIVE - 1)) begin
                     l_cnt_d = '0;
                     state_d = V_FRONT;
                  end else begin
                     l_cnt_d = l_inc;
                  end
               end
            end
            V_FRONT: begin
               h_cnt_d = h_inc;
               if (h_wrap) begin
                  if (l_cnt_q == LW'(V_FRONT_LINES - 1)) begin
                     l_cnt_d      = '0;
                     frame_done_d = 1'b1;
                     if (en) begin
                        state_d       = VSYNC_S;
                        frame_start_d = 1'b1;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     l_cnt_d = l_inc;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               h_cnt_d = '0;
               l_cnt_d = '0;
            end
         endcase

         vsync_d = (state_d == VSYNC_S);
         href_d  = (state_d == ACTIVE) && (32'(h_cnt_d) < H_ACTIVE);
         data_d  = '0;
         if (href_d) begin
`ifdef OV7670_TEST_PATTERN_EN
            data_d = DWIDTH'(h_cnt_d) ^ DWIDTH'(l_cnt_d);
`else
            if (pix_valid) begin
               data_d      = pix_data;
               pix_ready_d = 1'b1;
            end else begin
               underflow_d = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         h_cnt_q       <= '0;
         l_cnt_q       <= '0;
         pclk_q        <= 1'b0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         data_q        <= '0;
         pix_ready_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_cnt_q       <= h_cnt_d;
         l_cnt_q       <= l_cnt_d;
         pclk_q        <= PCLK;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         data_q        <= data_d;
         pix_ready_q   <= pix_ready_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         underflow_q   <= underflow_d;
      end
   end

   assign VSYNC       = vsync_q;
   assign HREF        = href_q;
   assign data        = data_q;
   assign pix_ready   = pix_ready_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_ov7670_frame_tx.sv
// Bench for ov7670_frame_tx: per-tick outputs predicted from the frame's period index.
module tb_ov7670_frame_tx;

   localparam int HA = 4, HB = 2, VA = 2, VSL = 1, VBL = 1, VFL = 1, DW = 10;
   localparam int LT        = HA + HB;
   localparam int ACT_START = (VSL + VBL) * LT;
   localparam int ACT_END   = ACT_START + VA * LT;
   localparam int FRAME_P   = ACT_END + VFL * LT;

   logic          clk = 1'b0;
   logic          PCLK = 1'b0;
   logic          rst, en, pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready, VSYNC, HREF, frame_start, frame_done, underflow;
   logic [DW-1:0] data;

   int            n_checks = 0;
   int            n_err = 0;
   logic [DW-1:0] words [0:8];
   logic          uf_model = 1'b0;
   logic          o;

   ov7670_frame_tx #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VSL),
      .V_BACK_LINES(VBL), .V_FRONT_LINES(VFL), .DWIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .PCLK(PCLK),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .VSYNC(VSYNC), .HREF(HREF), .data(data),
      .frame_start(frame_start), .frame_done(frame_done), .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #12;
      forever #20 PCLK = ~PCLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input logic vs, input logic hr, input logic [DW-1:0] d,
                          input logic fs, input logic fd, input logic pr, input logic uf);
      chk("vsync", 32'(VSYNC), 32'(vs));
      chk("href", 32'(HREF), 32'(hr));
      chk("data", 32'(data), 32'(d));
      chk("frame_start", 32'(frame_start), 32'(fs));
      chk("frame_done", 32'(frame_done), 32'(fd));
      chk("pix_ready", 32'(pix_ready), 32'(pr));
      chk("underflow", 32'(underflow), 32'(uf));
   endtask

   // Wait for the clk edge that reacts to the next PCLK rise, then check.
   task automatic tick_check(input logic vs, input logic hr, input logic [DW-1:0] d,
                             input logic fs, input logic fd, input logic pr, input logic uf,
                             output logic obs_pr);
      @(posedge PCLK);
      @(posedge clk);
      @(negedge clk);
      chk_all(vs, hr, d, fs, fd, pr, uf);
      obs_pr = pix_ready;
      if (fs || fd) begin
         @(negedge clk);
         chk("frame_start_pulse", 32'(frame_start), 32'(0));
         chk("frame_done_pulse", 32'(frame_done), 32'(0));
      end
   endtask

   task automatic fill_words(input bit fixed);
      for (int i = 0; i < 8; i++)
         words[i] = fixed ? DW'(i + 1) : DW'($urandom_range(1, 1023));
      words[8] = '0;
   endtask

   // Period p of a frame: [0,ACT_START) sync/back porch, then VA lines, then front porch.
   task automatic run_frame(input logic fd0, input int bad, input int drop_p, input int last_p);
      int idx = 0;
      int exp_pr = 0;
      int obs_pr = 0;
      logic op;
      for (int p = 0; p < last_p; p++) begin
         int a;
         bit act;
         int slot;
         logic [DW-1:0] ed;
         logic epr;
         a    = p - ACT_START;
         act  = (p >= ACT_START) && (p < ACT_END) && ((a % LT) < HA);
         slot = act ? (a / LT) * HA + (a % LT) : -1;
         if (p == drop_p) en = 1'b0;
         pix_valid = !(act && (slot == bad));
         pix_data  = words[idx];
         ed  = '0;
         epr = 1'b0;
         if (act) begin
`ifdef OV7670_TEST_PATTERN_EN
            ed = DW'((a % LT) ^ (a / LT));
`else
            if (pix_valid) begin
               ed  = words[idx];
               epr = 1'b1;
               idx++;
            end else begin
               uf_model = 1'b1;
            end
`endif
         end
         exp_pr += int'(epr);
         tick_check(p < VSL * LT, act, ed, p == 0, (p == 0) && fd0, epr, uf_model, op);
         obs_pr += int'(op);
      end
      if (last_p == FRAME_P) chk("pix_ready_count", 32'(obs_pr), 32'(exp_pr));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Idle with en low: nothing starts.
      repeat (2) tick_check(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);

      // Frame 1: fixed stream 1..8, en held so frame 2 follows back-to-back.
      fill_words(1'b1);
      en = 1'b1;
      run_frame(1'b0, -1, -1, FRAME_P);

      // Frame 2: random words, 3rd active word missing, en dropped in line 1.
      fill_words(1'b0);
      run_frame(1'b1, 2, ACT_START + 1, FRAME_P);
      tick_check(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, uf_model, o);
      repeat (3) tick_check(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, uf_model, o);

      // Frame 3: reset while HREF is high.
      fill_words(1'b0);
      en = 1'b1;
      run_frame(1'b0, -1, -1, ACT_START + 3);
      chk("href_before_rst", 32'(HREF), 32'(1));
      en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      uf_model = 1'b0;
      chk_all(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) tick_check(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);

      // Frame 4: random stream with a random (possibly absent) missing word.
      fill_words(1'b0);
      en = 1'b1;
      run_frame(1'b0, int'($urandom_range(0, 15)), -1, FRAME_P);
      en = 1'b0;
      tick_check(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, uf_model, o);
      tick_check(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, uf_model, o);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ov7670_frame_tx.md
Name: ov7670_frame_tx

Overview:
- Synthesizable OV7670-style sensor-side transmitter: drives VSYNC, HREF and 10-bit pixel data toward the camera capture master.
- Paced by the master's PCLK output, which is edge-detected in the single system clock domain.
- Pixels come from an upstream valid/ready stream.
- Used as a camera stand-in for bring-up and closed-loop simulation of the capture path.

Parameters:
- H_ACTIVE, 640, data words per line with HREF high
- H_BLANK, 144, PCLK ticks per line with HREF low
- V_ACTIVE, 480, active lines per frame
- VSYNC_LINES, 3, line periods with VSYNC high
- V_BACK_LINES, 17, line periods after VSYNC falls, before the first active line
- V_FRONT_LINES, 10, line periods after the last active line, before the next VSYNC
- DWIDTH, 10, data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  frame generation enable
- PCLK  in  1  pixel clock from the capture master, sampled in the clk domain
- pix_data  in  DWIDTH  upstream pixel word
- pix_valid  in  1  upstream word valid
- pix_ready  out  1  one-clk pulse; word consumed this cycle
- VSYNC  out  1  frame sync
- HREF  out  1  line valid
- data  out  DWIDTH  pixel data to the master
- frame_start  out  1  one-clk pulse when VSYNC rises
- frame_done  out  1  one-clk pulse when V_FRONT ends
- underflow  out  1  sticky: an active tick occurred with pix_valid low

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pclk_d 0.
- Tick generation:
  - pclk_d <= PCLK.
  - tick = PCLK & ~pclk_d.
  - All timing advances only on tick.
  - Outputs are registered and change in the clk cycle after the tick is detected, i.e. one clk after the PCLK rising edge is sampled.
  - The master samples on the following PCLK edge. PCLK must be slower than clk/2; the block does not check this.
- Counters:
  - h_cnt runs 0..H_ACTIVE+H_BLANK-1 (LINE_TOTAL).
  - l_cnt counts lines within the current state.
  - Widths are $clog2 of the max value plus 1, unsigned, wrapping to 0 at the terminal count.
- FSM states: IDLE, VSYNC_S, V_BACK, ACTIVE, V_FRONT.
  - IDLE: VSYNC=0, HREF=0, data=0. On tick with en=1, go to VSYNC_S with VSYNC=1, pulse frame_start, and set h_cnt=l_cnt=0.
  - VSYNC_S: after VSYNC_LINES*LINE_TOTAL ticks, VSYNC <= 0 and go to V_BACK.
  - V_BACK: after V_BACK_LINES*LINE_TOTAL ticks, go to ACTIVE at h_cnt=0.
  - ACTIVE:
    - h_cnt < H_ACTIVE: HREF=1. Each tick pulses pix_ready and sets data <= pix_data if pix_valid=1. If pix_valid=0, data <= 0 and underflow <= 1.
    - h_cnt >= H_ACTIVE: HREF=0 and data=0.
    - After V_ACTIVE lines, go to V_FRONT.
  - V_FRONT: after V_FRONT_LINES*LINE_TOTAL ticks, pulse frame_done. If en=1, go to VSYNC_S (pulse frame_start, VSYNC=1); otherwise go to IDLE.
- pix_ready is asserted only in the ACTIVE state with HREF=1, on tick cycles; never otherwise.
- Deasserting en mid-frame does not truncate the frame; it completes through V_FRONT, then goes to IDLE.
- rst mid-frame: immediate return to IDLE next clk with all outputs 0. underflow clears only on rst.
- VSYNC and HREF are never high together.
- data is 0 whenever HREF=0.

Optional Feature:
- Macro OV7670_TEST_PATTERN_EN.
- Defined:
  - pix_data and pix_valid are ignored and pix_ready is held 0.
  - data = {h_cnt[DWIDTH-1:0] ^ l_cnt[DWIDTH-1:0]} during HREF.
  - underflow is held 0.
- Undefined: the streamed behaviour above.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, VSYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1, and PCLK = clk/4.
1. rst=1, then en=1 with a valid stream 0x001..0x008 -> VSYNC high for 6 ticks, low 6 ticks, then HREF high 4 ticks carrying 0x001..0x004, low 2, high with 0x005..0x008. frame_done occurs 6 ticks after the last line. frame_start and frame_done are single-clk pulses.
2. pix_valid=0 on the 3rd active tick -> data=0 on that tick, underflow=1 and stays 1 until rst. The remaining words are not skipped.
3. en dropped during line 1 of ACTIVE -> the frame completes normally, frame_done pulses, state returns to IDLE, and VSYNC stays 0 afterwards.
4. en held 1 -> back-to-back frames; frame_start is in the same clk as frame_done; 8 pix_ready pulses per frame exactly.
5. rst asserted while HREF=1 -> the next clk has VSYNC=HREF=0, data=0, pix_ready=0, underflow=0, and a restart requires a tick with en=1.
6. OV7670_TEST_PATTERN_EN defined -> line 1 data = 0x001,0x000,0x003,0x002; pix_ready never asserted.
